// File: rtl/keypad_scan_dev_if.sv
// Key-event interface of the keypad scanner.
//   key_state : debounced key map, bit row*4+col, 1 = pressed
//   key_code  : index of the reported press
//   key_valid : a press event is pending
//   key_ack   : the consumer accepts the pending event
//   overrun   : sticky, a press was dropped while an event was pending
// master = scanner side, slave = consumer side.
interface keypad_scan_dev_if;
    logic [15:0] key_state;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        overrun;

    modport master (
        output key_state,
        output key_code,
        output key_valid,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_state,
        input  key_code,
        input  key_valid,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/keypad_scan_dev.sv
// 4x4 hex keypad scanner.
// Drives one active-low row at a time for SCAN_DIV cycles and samples the
// synchronized active-low columns at the end of each row slot. Whole frames
// are debounced: a frame must repeat DEBOUNCE_SCANS times before it becomes
// the debounced map. Newly pressed keys raise an event (lowest index wins)
// that is delivered through a valid/ack handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   COL        : keypad columns, active-low, asynchronous to clk
//   ROW        : keypad row drive, active-low, one bit low at a time
//   bus        : key_state / key_code / key_valid / key_ack / overrun
module keypad_scan_dev #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        COL,
    output logic [3:0]        ROW,
    keypad_scan_dev_if.master bus
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    // Lowest set index of a 16-bit map (0 when the map is empty).
    function automatic logic [3:0] lowest_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [3:0]       col_meta_r;
    logic [3:0]       col_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       row_idx_r;
    logic [3:0]       row_r;
    logic [15:0]      raw_r;
    logic [15:0]      prev_frame_r;
    logic [CNT_W-1:0] stable_cnt_r;
    logic             accept_r;
    logic [15:0]      accept_frame_r;
    logic [15:0]      key_state_r;
    logic             ev_valid_r;
    logic [3:0]       ev_code_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic             overrun_r;

    logic             sample_s;
    logic             frame_done_s;
    logic [1:0]       next_row_s;
    logic [15:0]      frame_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [15:0]      new_s;

    // Scan timing, assembled frame, next debounce count and new-press map.
    always_comb begin
        sample_s     = (div_r == DIV_W'(SCAN_DIV - 1));
        frame_done_s = sample_s && (row_idx_r == 2'd3);
        next_row_s   = row_idx_r + 2'd1;
        // Row 3 is sampled in this very cycle, so it comes straight from the synchronizer.
        frame_s      = {~col_sync_r, raw_r[11:0]};
        if (frame_s == prev_frame_r) begin
            if (stable_cnt_r == CNT_W'(DEBOUNCE_SCANS)) begin
                cnt_next_s = stable_cnt_r;
            end else begin
                cnt_next_s = stable_cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = CNT_W'(1);
        end
        new_s = accept_frame_r & ~key_state_r;
    end

    // Two-flop synchronizer for the asynchronous column inputs (idle high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= COL;
            col_sync_r <= col_meta_r;
        end
    end

    // Row divider, row drive and per-row column capture at the end of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= '0;
            row_idx_r <= 2'd0;
            row_r     <= 4'b1110;
            raw_r     <= 16'h0000;
        end else if (sample_s) begin
            div_r     <= '0;
            row_idx_r <= next_row_s;
            row_r     <= ~(4'b0001 << next_row_s);
            raw_r[{row_idx_r, 2'b00} +: 4] <= ~col_sync_r;
        end else begin
            div_r     <= div_r + DIV_W'(1);
        end
    end

    // Frame debounce: count identical consecutive frames and flag acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_frame_r   <= 16'h0000;
            stable_cnt_r   <= '0;
            accept_r       <= 1'b0;
            accept_frame_r <= 16'h0000;
        end else if (frame_done_s) begin
            prev_frame_r   <= frame_s;
            stable_cnt_r   <= cnt_next_s;
            accept_r       <= (cnt_next_s >= CNT_W'(DEBOUNCE_SCANS)) && (frame_s != key_state_r);
            accept_frame_r <= frame_s;
        end else begin
            accept_r       <= 1'b0;
        end
    end

    // Debounced map update; the press event is taken against the old map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_r <= 16'h0000;
            ev_valid_r  <= 1'b0;
            ev_code_r   <= 4'd0;
        end else if (accept_r) begin
            key_state_r <= accept_frame_r;
            ev_valid_r  <= |new_s;
            ev_code_r   <= lowest_index(new_s);
        end else begin
            ev_valid_r  <= 1'b0;
        end
    end

    // Valid/ack handshake with overrun tracking; an ack in the event cycle lets
    // the new event replace the pending one instead of being dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (ev_valid_r) begin
            if (!key_valid_r) begin
                key_valid_r <= 1'b1;
                key_code_r  <= ev_code_r;
            end else if (bus.key_ack) begin
                key_code_r  <= ev_code_r;
                overrun_r   <= 1'b0;
            end else begin
                overrun_r   <= 1'b1;
            end
        end else if (key_valid_r && bus.key_ack) begin
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            key_valid_r <= key_valid_r;
        end
    end

    assign ROW           = row_r;
    assign bus.key_state = key_state_r;
    assign bus.key_code  = key_code_r;
    assign bus.key_valid = key_valid_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: doc/keypad_scan_dev.md
Name: keypad_scan_dev

Overview:
- Input-side counterpart of the multiplexed seven-segment driver. It time-multiplexes the row lines of a 4x4 hex keypad (active-low drive), samples the column lines, debounces whole scan frames, and delivers key-press codes to the CPU/IO bus.
- Delivery uses a valid/ack handshake. A 16-bit debounced key map is also exposed, so pressed keys can be shown on the 7-seg/LED path.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven. Minimum 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full frames needed before the debounced map updates. Minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- COL  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- ROW  output  4  keypad row drive, active-low, exactly one bit low at all times
- key_state  output  16  debounced map; bit i=row*4+col, 1=pressed
- key_code  output  4  index of the reported press (row*4+col)
- key_valid  output  1  press event pending
- key_ack  input  1  consumer accepts the pending event
- overrun  output  1  sticky: a press was dropped while an event was pending

Behaviour:
- Reset, asynchronous on rst_n low:
  - ROW=4'b1110, key_state=0, key_code=0, key_valid=0, overrun=0.
  - Divider, row index, frame buffer, previous frame and stable counter all clear. COL synchronizer flops are set to 1.
  - Reset asserted mid-frame discards the partial frame; scanning restarts at row 0.
- COL synchronizer: 2 flops on clk. All sampling uses the synchronized value.
- Scan:
  - div counts 0..SCAN_DIV-1 and wraps.
  - row_idx increments modulo 4 when div wraps.
  - ROW = ~(4'b0001 << row_idx).
  - On div==SCAN_DIV-1, raw[row_idx*4 +: 4] <= ~col_sync. The sample is taken at the end of the slot to allow settling and synchronizer delay.
- Frame completion: the sample cycle of row 3.
  - If the assembled frame equals prev_frame, stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise prev_frame <= frame and stable_cnt <= 1.
  - If after this update stable_cnt >= DEBOUNCE_SCANS and frame != key_state, key_state <= frame on the next cycle.
  - With DEBOUNCE_SCANS=1 every frame is accepted.
- Press detection:
  - new = frame & ~key_state, evaluated in the cycle key_state updates.
  - Releases produce no event.
  - If new != 0, the event code is the lowest set index. Other simultaneous new presses appear only in key_state.
- Handshake, registered, one cycle after the key_state update:
  - key_valid=0: key_valid<=1, key_code<=event code.
  - key_valid=1 and key_ack=1 in the event cycle: the new event replaces the pending one; key_valid stays 1; overrun is cleared.
  - key_valid=1 and key_ack=0: event dropped, overrun<=1, key_code unchanged.
  - Without an event: key_ack=1 while key_valid=1 gives key_valid<=0 and overrun<=0 next cycle.
  - key_ack while key_valid=0 is ignored.
  - key_code holds its value after ack.
- Latency:
  - Frame length is 4*SCAN_DIV cycles.
  - A clean press held from before a frame starts is reported after DEBOUNCE_SCANS complete frames, plus 2 cycles (key_state update, then valid).
- Glitch shorter than one frame: frame mismatch resets stable_cnt; no key_state change and no event.

Test Plan:
- Reset check: with SCAN_DIV=4, DEBOUNCE_SCANS=2, hold rst_n=0, then release -> ROW=1110 immediately; ROW walks 1101, 1011, 0111 every 4 cycles, then wraps to 1110; all outputs 0.
- Single press, same parameters: model ties COL[2]=0 when ROW[1]=0 (key 6) from frame start -> key_state=16'h0040 after 2 frames (32 cycles) +1; key_valid=1 with key_code=6 one cycle later; key_ack pulse -> key_valid=0 next cycle.
- Bounce: key 6 toggles every 5 cycles for 3 frames, then is held -> no event during bouncing; exactly one event (code 6) 2 stable frames after settling.
- Multi-key: keys 9 and 3 pressed in the same frame -> key_state=16'h0208, single event key_code=3; releasing 3 while holding 9 -> key_state=16'h0200, no event.
- Overrun: press key 1 without ack, release, then press key 0xF -> key_valid stays 1, key_code=1, overrun=1; ack -> key_valid=0, overrun=0.
- Ack collision and reset: ack asserted in the same cycle a new press (key 0xA) registers -> key_valid stays 1, key_code=0xA, overrun=0. Then rst_n pulse mid-frame -> all outputs 0 and ROW=1110 immediately.
